// File: rtl/param_response_checker_pkg.sv
// Shared definitions for the response checker and the inverter workshop benches.
package param_response_checker_pkg;

    // Default data and counter widths, also used by the inverter testbench.
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_COUNT_W = 16;

    // Checker FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } chk_state_e;

endpackage

// File: rtl/param_response_checker_expect.sv
// Combinational expected-value and mismatch generation for an inverter response.
// INVERT=1 expects the bitwise complement of the stimulus; INVERT=0 expects a pass-through.
module param_expect #(
    parameter int WIDTH  = 8,
    parameter bit INVERT = 1'b1
) (
    input  logic [WIDTH-1:0] stim_i,
    input  logic [WIDTH-1:0] resp_i,
    output logic [WIDTH-1:0] expected_o,
    output logic             mismatch_o
);

    generate
        if (INVERT) begin : g_invert
            assign expected_o = ~stim_i;
        end else begin : g_pass
            assign expected_o = stim_i;
        end
    endgenerate

    assign mismatch_o = (resp_i != expected_o);

endmodule

// File: rtl/param_response_checker.sv
// Self-checking monitor: counts stim/resp vectors, counts mismatches (saturating),
// captures the first failing pair and reports pass/fail after a programmed run length.
module param_response_checker
    import param_response_checker_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter bit INVERT  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_vectors,
    input  logic               valid,
    input  logic [WIDTH-1:0]   stim,
    input  logic [WIDTH-1:0]   resp,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] vec_count,
    output logic [COUNT_W-1:0] err_count,
    output logic               err_flag,
    output logic [WIDTH-1:0]   first_err_stim,
    output logic [WIDTH-1:0]   first_err_resp
);

    chk_state_e         state_q;
    logic [COUNT_W-1:0] target_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [COUNT_W-1:0] vec_q;
    logic [COUNT_W-1:0] err_q;
    logic               flag_q;
    logic [WIDTH-1:0]   fstim_q;
    logic [WIDTH-1:0]   fresp_q;

    logic [COUNT_W-1:0] vec_d;
    logic [COUNT_W-1:0] err_d;
    logic [WIDTH-1:0]   expected;
    logic               mismatch;

    param_expect #(
        .WIDTH  (WIDTH),
        .INVERT (INVERT)
    ) u_expect (
        .stim_i     (stim),
        .resp_i     (resp),
        .expected_o (expected),
        .mismatch_o (mismatch)
    );

    // Counter values after accepting the current vector; error count sticks at all-ones.
    always_comb begin
        vec_d = vec_q + 1'b1;
        err_d = err_q;
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    // Run-control FSM with registered status, counters and first-error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            vec_q    <= '0;
            err_q    <= '0;
            flag_q   <= 1'b0;
            fstim_q  <= '0;
            fresp_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // valid is ignored here; a start in the same cycle arms the run
                    // and the first vector counted is the one on the next cycle.
                    if (start) begin
                        vec_q   <= '0;
                        err_q   <= '0;
                        flag_q  <= 1'b0;
                        fstim_q <= '0;
                        fresp_q <= '0;
                        if (num_vectors != '0) begin
                            target_q <= num_vectors;
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            pass_q   <= 1'b0;
                        end else begin
                            // Empty run completes immediately and trivially passes.
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (valid) begin
                        vec_q <= vec_d;
                        err_q <= err_d;
                        if (mismatch && !flag_q) begin
                            flag_q  <= 1'b1;
                            fstim_q <= stim;
                            fresp_q <= resp;
                        end
                        // The final vector's verdict is folded into pass on the same edge.
                        if (vec_d == target_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign vec_count      = vec_q;
    assign err_count      = err_q;
    assign err_flag       = flag_q;
    assign first_err_stim = fstim_q;
    assign first_err_resp = fresp_q;

endmodule

// File: tb/tb_param_response_checker.sv
// Bench for param_response_checker: two instances (4-bit inverter check with 16-bit
// counters, and 4-bit pass-through check with 2-bit counters) compared every cycle
// against a run-level reference model, plus directed end-of-run checks.
module tb_param_response_checker;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  stim = '0;
    logic        start0 = 1'b0;
    logic [15:0] nv0 = '0;
    logic [3:0]  resp0 = '0;
    logic        start1 = 1'b0;
    logic [1:0]  nv1 = '0;
    logic [3:0]  resp1 = '0;

    logic        busy0, done0, pass0, flag0;
    logic [15:0] vec0, err0;
    logic [3:0]  fs0, fr0;
    logic        busy1, done1, pass1, flag1;
    logic [1:0]  vec1, err1;
    logic [3:0]  fs1, fr1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = inverter checker, 1 = pass-through checker.
    int ph[2];
    int tgt[2];
    int vc[2];
    int ec[2];
    int ff[2];
    int mfs[2];
    int mfr[2];
    int cmax[2];
    bit inv[2];

    always #5 clk = ~clk;

    param_response_checker #(.WIDTH(4), .COUNT_W(16), .INVERT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .num_vectors(nv0), .valid(valid),
        .stim(stim), .resp(resp0), .busy(busy0), .done(done0), .pass(pass0),
        .vec_count(vec0), .err_count(err0), .err_flag(flag0),
        .first_err_stim(fs0), .first_err_resp(fr0)
    );

    param_response_checker #(.WIDTH(4), .COUNT_W(2), .INVERT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .num_vectors(nv1), .valid(valid),
        .stim(stim), .resp(resp1), .busy(busy1), .done(done1), .pass(pass1),
        .vec_count(vec1), .err_count(err1), .err_flag(flag1),
        .first_err_stim(fs1), .first_err_resp(fr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = P_IDLE; tgt[k] = 0; vc[k] = 0; ec[k] = 0;
            ff[k] = 0; mfs[k] = 0; mfr[k] = 0;
        end
    endtask

    // One clock edge of a checker as described by the run rules.
    task automatic model_step(input int k, input bit st, input int nv, input bit v,
                              input int s, input int r);
        int e;
        if (ph[k] != P_RUN) begin
            if (st) begin
                vc[k] = 0; ec[k] = 0; ff[k] = 0; mfs[k] = 0; mfr[k] = 0;
                if (nv != 0) begin
                    ph[k] = P_RUN;
                    tgt[k] = nv;
                end else begin
                    ph[k] = P_DONE;
                end
            end
        end else if (v) begin
            e = inv[k] ? (~s & 15) : s;
            vc[k]++;
            if (r != e) begin
                if (ec[k] < cmax[k]) ec[k]++;
                if (ff[k] == 0) begin
                    ff[k] = 1; mfs[k] = s; mfr[k] = r;
                end
            end
            if (vc[k] == tgt[k]) ph[k] = P_DONE;
        end
    endtask

    // Advance one cycle, update the model, compare every output of both instances.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, start0, int'(nv0), valid, int'(stim), int'(resp0));
            model_step(1, start1, int'(nv1), valid, int'(stim), int'(resp1));
        end
        #1;
        check("busy0", busy0, ph[0] == P_RUN);
        check("done0", done0, ph[0] == P_DONE);
        check("pass0", pass0, (ph[0] == P_DONE) && (ec[0] == 0));
        check("vec0", vec0, vc[0]);
        check("err0", err0, ec[0]);
        check("flag0", flag0, ff[0]);
        check("fstim0", fs0, mfs[0]);
        check("fresp0", fr0, mfr[0]);
        check("busy1", busy1, ph[1] == P_RUN);
        check("done1", done1, ph[1] == P_DONE);
        check("pass1", pass1, (ph[1] == P_DONE) && (ec[1] == 0));
        check("vec1", vec1, vc[1]);
        check("err1", err1, ec[1]);
        check("flag1", flag1, ff[1]);
        check("fstim1", fs1, mfs[1]);
        check("fresp1", fr1, mfr[1]);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Present stim 0..n-1 back to back; stim values bad_a/bad_b get resp=0 on the inverter side.
    task automatic sweep(input int n, input int bad_a, input int bad_b);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            stim  = 4'(i);
            resp0 = (i == bad_a || i == bad_b) ? 4'h0 : ~4'(i);
            resp1 = 4'(i);
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic start_main(input int n);
        start0 = 1'b1;
        nv0 = 16'(n);
        tick();
    endtask

    initial begin
        cmax[0] = 65535; cmax[1] = 3;
        inv[0] = 1'b1;   inv[1] = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Happy path: start with a valid in the same cycle (must be ignored)
        valid = 1'b1; stim = 4'hA; resp0 = 4'h0;
        start_main(16);
        sweep(16, -1, -1);
        check("hp_done", done0, 1);
        check("hp_vec", vec0, 16);
        check("hp_err", err0, 0);
        check("hp_pass", pass0, 1);
        check("hp_flag", flag0, 0);
        $display("run happy: vec=%0d err=%0d pass=%0b", vec0, err0, pass0);

        // Single injected error at stim=5
        start_main(16);
        sweep(16, 5, -1);
        check("se_err", err0, 1);
        check("se_flag", flag0, 1);
        check("se_fstim", fs0, 4'b0101);
        check("se_fresp", fr0, 4'b0000);
        check("se_pass", pass0, 0);
        $display("run single-error: err=%0d first=%h/%h pass=%0b", err0, fs0, fr0, pass0);

        // Two errors: capture keeps the first one
        start_main(16);
        sweep(16, 3, 9);
        check("me_err", err0, 2);
        check("me_fstim", fs0, 4'b0011);
        $display("run multi-error: err=%0d first_stim=%h", err0, fs0);

        // Valid gaps, mid-run start with a new target is ignored
        start_main(4);
        for (int i = 0; i < 8; i++) begin
            valid = (i % 2) == 0;
            stim = 4'(i); resp0 = ~4'(i);
            if (i == 3) begin start0 = 1'b1; nv0 = 16'd2; end
            tick();
            if (i == 5) check("gap_notdone", done0, 0);
        end
        check("gap_done", done0, 1);
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; stim = 4'(i); resp0 = 4'(i);
            tick();
        end
        valid = 1'b0;
        check("gap_hold_vec", vec0, 4);
        check("gap_hold_pass", pass0, 1);
        $display("run gaps: vec=%0d done=%0b", vec0, done0);

        // Zero-length run
        start_main(0);
        check("zero_done", done0, 1);
        check("zero_pass", pass0, 1);
        check("zero_vec", vec0, 0);
        $display("run zero: done=%0b pass=%0b", done0, pass0);

        // Narrow counters, pass-through check, every vector wrong
        start1 = 1'b1; nv1 = 2'd3;
        tick();
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; stim = 4'(i + 6); resp1 = ~4'(i + 6);
            tick();
        end
        valid = 1'b0;
        check("sat_err", err1, 3);
        check("sat_done", done1, 1);
        check("sat_pass", pass1, 0);
        check("sat_fstim", fs1, 4'd6);
        $display("run narrow-all-wrong: err=%0d vec=%0d", err1, vec1);

        // Reset mid-run after 7 of 16 vectors, then a clean run
        start_main(16);
        sweep(7, -1, -1);
        rst = 1'b1; valid = 1'b1; stim = 4'd7; resp0 = 4'd7;
        tick();
        rst = 1'b0; valid = 1'b0;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_vec", vec0, 0);
        check("rst_flag", flag0, 0);
        start_main(16);
        sweep(16, -1, -1);
        check("rst_clean_pass", pass0, 1);
        $display("run after-reset: vec=%0d pass=%0b", vec0, pass0);

        // Randomized runs on both instances
        for (int run = 0; run < 14; run++) begin
            start0 = 1'b1; nv0 = 16'($urandom_range(0, 20));
            start1 = 1'b1; nv1 = 2'($urandom_range(0, 3));
            valid = $urandom_range(0, 1);
            tick();
            for (int c = 0; c < 60; c++) begin
                valid = ($urandom_range(0, 3) != 0);
                stim  = 4'($urandom);
                resp0 = ($urandom_range(0, 6) == 0) ? 4'($urandom) : ~stim;
                resp1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : stim;
                if ($urandom_range(0, 15) == 0) begin start0 = 1'b1; nv0 = 16'($urandom_range(0, 5)); end
                if ($urandom_range(0, 15) == 0) begin start1 = 1'b1; nv1 = 2'($urandom); end
                if ($urandom_range(0, 7) == 0) nv0 = 16'($urandom);
                tick();
            end
            valid = 1'b0;
            tick();
            $display("run random %0d: vec0=%0d err0=%0d pass0=%0b vec1=%0d err1=%0d pass1=%0b",
                     run, vec0, err0, pass0, vec1, err1, pass1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
